// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order completion buffer with CDB writeback, retire and flush
package rob_pkg;
    typedef logic [31:0] MemoryWord;
    typedef struct packed {
        logic      valid;
        logic      ready;
        logic [7:0] tag;
        logic [4:0] rd;
        logic [7:0] ctrl_bits;
        MemoryWord value;
    } rob_entry;
endpackage

module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    input  rob_entry         alloc_entry,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             full,
    output logic             empty,
    output logic [TAG_W:0]   count,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  MemoryWord        cdb_value,
    output rob_entry         rob_head,
    input  logic             rob_decrement,
    input  logic             flush
);
    rob_entry         slots [DEPTH];
    logic [TAG_W-1:0] head, tail;
    logic             do_alloc, do_ret;

    always_comb begin
        full      = count == (TAG_W+1)'(DEPTH);
        empty     = count == '0;
        alloc_tag = tail;
        do_alloc  = alloc_valid && !full;
        do_ret    = rob_decrement && !empty;
        rob_head  = empty ? '0 : slots[head];
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            slots <= '{default: '0};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_valid && cdb_tag == TAG_W'(i) && slots[i].valid) begin
                    slots[i].ready <= 1'b1;
                    slots[i].value <= cdb_value;
                end
                if (do_ret && head == TAG_W'(i)) begin
                    slots[i].valid <= 1'b0;
                    slots[i].ready <= 1'b0;
                end
                if (do_alloc && tail == TAG_W'(i))
                    slots[i] <= '{valid: 1'b1, ready: 1'b0, tag: 8'(tail), rd: alloc_entry.rd,
                                  ctrl_bits: alloc_entry.ctrl_bits, value: '0};
            end
            head  <= head + TAG_W'(do_ret);
            tail  <= tail + TAG_W'(do_alloc);
            count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_ret);
        end
    end
endmodule
